// File: rtl/calc_input_fsm.sv
// ============================================================================
// calc_input_fsm
// ----------------------------------------------------------------------------
// Purpose : Keypad input state machine for a four-digit add/subtract
//           calculator. Level inputs from the keypad decoder are turned into
//           single key events on the rising edge of "any key held"; events
//           build operand A, operator, operand B and finally a result.
//
// Ports   :
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   is_num       in   1   digit key held
//   is_op        in   1   operator key held
//   is_eq        in   1   equals key held
//   num_val      in   4   digit value 0..9 (valid with is_num)
//   op_val       in   2   operator code 1=plus, 2=minus, 0/3 invalid
//   disp_val     out  15  unsigned magnitude shown on the display
//   disp_neg     out  1   displayed value is negative
//   err          out  1   result magnitude exceeds 9999
//   result_valid out  1   one-cycle pulse when a result is loaded
//   state        out  2   0=ENTER_A, 1=ENTER_B, 2=RESULT
//
// Configuration :
//   CALC_CHAIN_EN  when defined, an operator pressed while a clean
//                  (non-negative, non-error) result is displayed continues
//                  the calculation with that result as operand A.
//                  Undefined (default): operators in RESULT are ignored.
// ============================================================================
module calc_input_fsm (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        is_num,
   input  logic        is_op,
   input  logic        is_eq,
   input  logic [3:0]  num_val,
   input  logic [1:0]  op_val,
   output logic [14:0] disp_val,
   output logic        disp_neg,
   output logic        err,
   output logic        result_valid,
   output logic [1:0]  state
);

   localparam logic [1:0]  ST_ENTER_A = 2'd0;
   localparam logic [1:0]  ST_ENTER_B = 2'd1;
   localparam logic [1:0]  ST_RESULT  = 2'd2;

   localparam logic [1:0]  OP_PLUS    = 2'd1;
   localparam logic [1:0]  OP_MINUS   = 2'd2;

   localparam logic [2:0]  MAX_DIGITS = 3'd4;
   localparam logic [14:0] MAX_MAG    = 15'd9999;

   // X*10 + d; callers guarantee X <= 999 so the result fits 14 bits.
   function automatic logic [13:0] append_digit(input logic [13:0] x,
                                                input logic [3:0]  d);
      logic [17:0] w_t;
      w_t = ({4'd0, x} * 18'd10) + {14'd0, d};
      return w_t[13:0];
   endfunction

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [1:0]  r_state;
   logic        r_key_any_d;
   logic        r_rst_hold;     // 1 only in the first cycle after reset release
   logic [13:0] r_a;
   logic [13:0] r_b;
   logic [2:0]  r_cnt_a;
   logic [2:0]  r_cnt_b;
   logic        r_op_minus;
   logic [14:0] r_disp_val;
   logic        r_disp_neg;
   logic        r_err;
   logic        r_result_valid;

   // ------------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------------
   logic        w_key_any;
   logic        w_key_any_d;
   logic        w_event;
   logic        w_ev_num;
   logic        w_ev_op;
   logic        w_ev_eq;
   logic        w_num_ok;
   logic        w_op_ok;
   logic        w_op_is_minus;
`ifdef CALC_CHAIN_EN
   logic        w_chain;
`endif

   logic [1:0]  w_state_nxt;
   logic [13:0] w_a_nxt;
   logic [13:0] w_b_nxt;
   logic [2:0]  w_cnt_a_nxt;
   logic [2:0]  w_cnt_b_nxt;
   logic        w_op_minus_nxt;

   logic [14:0] w_res_mag;
   logic        w_res_neg;

   logic [14:0] w_disp_val_nxt;
   logic        w_disp_neg_nxt;
   logic        w_err_nxt;
   logic        w_result_valid_nxt;

   // ------------------------------------------------------------------------
   // Key event detection. Right after reset the previous-key flag is forced
   // high so that a key held through reset release produces no event.
   // ------------------------------------------------------------------------
   assign w_key_any   = is_num | is_op | is_eq;
   assign w_key_any_d = r_key_any_d | r_rst_hold;
   assign w_event     = w_key_any & ~w_key_any_d;

   // Class priority: equals over operator over digit.
   assign w_ev_eq  = w_event & is_eq;
   assign w_ev_op  = w_event & ~is_eq & is_op;
   assign w_ev_num = w_event & ~is_eq & ~is_op & is_num;

   assign w_num_ok      = (num_val <= 4'd9);
   assign w_op_ok       = (op_val == OP_PLUS) || (op_val == OP_MINUS);
   assign w_op_is_minus = (op_val == OP_MINUS);

`ifdef CALC_CHAIN_EN
   assign w_chain = w_ev_op & w_op_ok & ~r_err & ~r_disp_neg;
`endif

   // Tracks key level and the post-reset suppression cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_any_d <= 1'b0;
         r_rst_hold  <= 1'b1;
      end else begin
         r_key_any_d <= w_key_any;
         r_rst_hold  <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_ENTER_A;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   // Next-state decode from the current state and the key event.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ENTER_A: begin
            if (w_ev_op && w_op_ok) begin
               w_state_nxt = ST_ENTER_B;
            end else begin
               w_state_nxt = ST_ENTER_A;
            end
         end
         ST_ENTER_B: begin
            if (w_ev_eq) begin
               w_state_nxt = ST_RESULT;
            end else begin
               w_state_nxt = ST_ENTER_B;
            end
         end
         ST_RESULT: begin
            if (w_ev_num && w_num_ok) begin
               w_state_nxt = ST_ENTER_A;
`ifdef CALC_CHAIN_EN
            end else if (w_chain) begin
               w_state_nxt = ST_ENTER_B;
`endif
            end else begin
               w_state_nxt = ST_RESULT;
            end
         end
         default: begin
            w_state_nxt = ST_ENTER_A;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Operand / operator datapath
   // ------------------------------------------------------------------------
   // Next operand, digit-count and operator values for the current event.
   always_comb begin
      w_a_nxt        = r_a;
      w_b_nxt        = r_b;
      w_cnt_a_nxt    = r_cnt_a;
      w_cnt_b_nxt    = r_cnt_b;
      w_op_minus_nxt = r_op_minus;
      case (r_state)
         ST_ENTER_A: begin
            if (w_ev_num && w_num_ok && (r_cnt_a < MAX_DIGITS)) begin
               w_a_nxt     = append_digit(r_a, num_val);
               w_cnt_a_nxt = r_cnt_a + 3'd1;
            end else if (w_ev_op && w_op_ok) begin
               w_op_minus_nxt = w_op_is_minus;
               w_b_nxt        = 14'd0;
               w_cnt_b_nxt    = 3'd0;
            end else begin
               w_a_nxt = r_a;
            end
         end
         ST_ENTER_B: begin
            if (w_ev_num && w_num_ok && (r_cnt_b < MAX_DIGITS)) begin
               w_b_nxt     = append_digit(r_b, num_val);
               w_cnt_b_nxt = r_cnt_b + 3'd1;
            end else if (w_ev_op && w_op_ok && (r_cnt_b == 3'd0)) begin
               // Operator may be changed until the first B digit.
               w_op_minus_nxt = w_op_is_minus;
            end else begin
               w_b_nxt = r_b;
            end
         end
         ST_RESULT: begin
            if (w_ev_num && w_num_ok) begin
               w_a_nxt     = {10'd0, num_val};
               w_cnt_a_nxt = 3'd1;
               w_b_nxt     = 14'd0;
               w_cnt_b_nxt = 3'd0;
`ifdef CALC_CHAIN_EN
            end else if (w_chain) begin
               // A clean result is at most 9999, so it fits operand A.
               w_a_nxt        = r_disp_val[13:0];
               w_cnt_a_nxt    = MAX_DIGITS;
               w_op_minus_nxt = w_op_is_minus;
               w_b_nxt        = 14'd0;
               w_cnt_b_nxt    = 3'd0;
`endif
            end else begin
               w_a_nxt = r_a;
            end
         end
         default: begin
            w_a_nxt        = 14'd0;
            w_b_nxt        = 14'd0;
            w_cnt_a_nxt    = 3'd0;
            w_cnt_b_nxt    = 3'd0;
            w_op_minus_nxt = 1'b0;
         end
      endcase
   end

   // Operand and operator registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a        <= 14'd0;
         r_b        <= 14'd0;
         r_cnt_a    <= 3'd0;
         r_cnt_b    <= 3'd0;
         r_op_minus <= 1'b0;
      end else begin
         r_a        <= w_a_nxt;
         r_b        <= w_b_nxt;
         r_cnt_a    <= w_cnt_a_nxt;
         r_cnt_b    <= w_cnt_b_nxt;
         r_op_minus <= w_op_minus_nxt;
      end
   end

   // Arithmetic on the stored operands; B is zero when no B digit was keyed.
   always_comb begin
      w_res_mag = 15'd0;
      w_res_neg = 1'b0;
      if (!r_op_minus) begin
         w_res_mag = {1'b0, r_a} + {1'b0, r_b};
         w_res_neg = 1'b0;
      end else if (r_b > r_a) begin
         w_res_mag = {1'b0, r_b} - {1'b0, r_a};
         w_res_neg = 1'b1;
      end else begin
         w_res_mag = {1'b0, r_a} - {1'b0, r_b};
         w_res_neg = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: output logic (next values, registered below)
   // ------------------------------------------------------------------------
   // Display selection follows the state being entered.
   always_comb begin
      w_disp_val_nxt     = r_disp_val;
      w_disp_neg_nxt     = 1'b0;
      w_err_nxt          = 1'b0;
      w_result_valid_nxt = (r_state == ST_ENTER_B) && (w_state_nxt == ST_RESULT);
      case (w_state_nxt)
         ST_ENTER_A: begin
            w_disp_val_nxt = {1'b0, w_a_nxt};
         end
         ST_ENTER_B: begin
            if (w_cnt_b_nxt == 3'd0) begin
               w_disp_val_nxt = {1'b0, w_a_nxt};
            end else begin
               w_disp_val_nxt = {1'b0, w_b_nxt};
            end
         end
         ST_RESULT: begin
            if (r_state != ST_RESULT) begin
               w_disp_val_nxt = w_res_mag;
               w_disp_neg_nxt = w_res_neg;
               w_err_nxt      = (w_res_mag > MAX_MAG);
            end else begin
               w_disp_val_nxt = r_disp_val;
               w_disp_neg_nxt = r_disp_neg;
               w_err_nxt      = r_err;
            end
         end
         default: begin
            w_disp_val_nxt = 15'd0;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_disp_val     <= 15'd0;
         r_disp_neg     <= 1'b0;
         r_err          <= 1'b0;
         r_result_valid <= 1'b0;
      end else begin
         r_disp_val     <= w_disp_val_nxt;
         r_disp_neg     <= w_disp_neg_nxt;
         r_err          <= w_err_nxt;
         r_result_valid <= w_result_valid_nxt;
      end
   end

   assign disp_val     = r_disp_val;
   assign disp_neg     = r_disp_neg;
   assign err          = r_err;
   assign result_valid = r_result_valid;
   assign state        = r_state;

endmodule

// File: tb/tb_calc_input_fsm.sv
module tb_calc_input_fsm;

   logic        clk;
   logic        rst_n;
   logic        is_num;
   logic        is_op;
   logic        is_eq;
   logic [3:0]  num_val;
   logic [1:0]  op_val;
   logic [14:0] disp_val;
   logic        disp_neg;
   logic        err;
   logic        result_valid;
   logic [1:0]  state;

   int n_cmp = 0;
   int n_bad = 0;
   int rv_cnt = 0;
   int rv_snap = 0;

   calc_input_fsm dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .is_num       (is_num),
      .is_op        (is_op),
      .is_eq        (is_eq),
      .num_val      (num_val),
      .op_val       (op_val),
      .disp_val     (disp_val),
      .disp_neg     (disp_neg),
      .err          (err),
      .result_valid (result_valid),
      .state        (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count result_valid high samples (one per cycle high).
   always @(negedge clk) begin
      if (rst_n && result_valid) rv_cnt <= rv_cnt + 1;
   end

   task automatic chk_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic press(input logic n, input logic o, input logic e,
                        input logic [3:0] nv, input logic [1:0] ov,
                        input int hold);
      @(negedge clk);
      is_num = n; is_op = o; is_eq = e; num_val = nv; op_val = ov;
      repeat (hold) @(negedge clk);
      is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0; num_val = 4'd0; op_val = 2'd0;
      repeat (3) @(negedge clk);
   endtask

   task automatic key_d(input logic [3:0] d);
      press(1'b1, 1'b0, 1'b0, d, 2'd0, 5);
   endtask

   task automatic key_o(input logic [1:0] o);
      press(1'b0, 1'b1, 1'b0, 4'd0, o, 5);
   endtask

   task automatic key_e();
      press(1'b0, 1'b0, 1'b1, 4'd0, 2'd0, 5);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
      num_val = 4'd0; op_val = 2'd0;
      repeat (3) @(negedge clk);
      chk_val("rst_disp",  int'(disp_val), 0);
      chk_val("rst_neg",   int'(disp_neg), 0);
      chk_val("rst_err",   int'(err), 0);
      chk_val("rst_rv",    int'(result_valid), 0);
      chk_val("rst_state", int'(state), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 12 + 34 = 46
      key_d(4'd1); chk_val("s1_a1", int'(disp_val), 1);
      key_d(4'd2); chk_val("s1_a12", int'(disp_val), 12);
      key_o(2'd1); chk_val("s1_op_state", int'(state), 1);
      chk_val("s1_op_disp", int'(disp_val), 12);
      key_d(4'd3); chk_val("s1_b3", int'(disp_val), 3);
      key_d(4'd4); chk_val("s1_b34", int'(disp_val), 34);
      rv_snap = rv_cnt;
      key_e();
      chk_val("s1_res", int'(disp_val), 46);
      chk_val("s1_neg", int'(disp_neg), 0);
      chk_val("s1_err", int'(err), 0);
      chk_val("s1_state", int'(state), 2);
      chk_val("s1_rv_pulses", rv_cnt - rv_snap, 1);
      chk_val("s1_rv_low", int'(result_valid), 0);

      // 5 - 9 = -4
      do_reset();
      key_d(4'd5); key_o(2'd2); key_d(4'd9); key_e();
      chk_val("s2_res", int'(disp_val), 4);
      chk_val("s2_neg", int'(disp_neg), 1);
      chk_val("s2_err", int'(err), 0);

      // 99999 (fifth ignored) + 9999 = 19998, overflow flagged
      do_reset();
      for (int i = 0; i < 5; i++) key_d(4'd9);
      chk_val("s3_a", int'(disp_val), 9999);
      key_o(2'd1);
      for (int i = 0; i < 4; i++) key_d(4'd9);
      chk_val("s3_b", int'(disp_val), 9999);
      key_e();
      chk_val("s3_res", int'(disp_val), 19998);
      chk_val("s3_err", int'(err), 1);
      chk_val("s3_neg", int'(disp_neg), 0);

      // long hold is one event; reset mid-hold; held key across release
      do_reset();
      press(1'b1, 1'b0, 1'b0, 4'd7, 2'd0, 20);
      chk_val("s4_hold", int'(disp_val), 7);
      @(negedge clk);
      is_num = 1'b1; num_val = 4'd7;
      repeat (5) @(negedge clk);
      chk_val("s4_a77", int'(disp_val), 77);
      rst_n = 1'b0;
      #2;
      chk_val("s4_async_disp", int'(disp_val), 0);
      chk_val("s4_async_state", int'(state), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk_val("s4_held_disp", int'(disp_val), 0);
      is_num = 1'b0; num_val = 4'd0;
      repeat (3) @(negedge clk);
      key_d(4'd7);
      chk_val("s4_repress", int'(disp_val), 7);

      // 8 + then - replaces op, 8 - 2 = 6
      do_reset();
      key_d(4'd8); key_o(2'd1); key_o(2'd2);
      chk_val("s5_state", int'(state), 1);
      key_d(4'd2); key_e();
      chk_val("s5_res", int'(disp_val), 6);
      chk_val("s5_neg", int'(disp_neg), 0);

      // priority, invalid op/digit
      do_reset();
      key_d(4'd5);
      key_o(2'd3);
      chk_val("s6_badop_state", int'(state), 0);
      key_e();
      chk_val("s6_eq_in_a", int'(state), 0);
      press(1'b1, 1'b1, 1'b0, 4'd6, 2'd1, 5);
      chk_val("s6_prio_state", int'(state), 1);
      chk_val("s6_prio_disp", int'(disp_val), 5);
      key_d(4'd10);
      chk_val("s6_baddigit", int'(disp_val), 5);
      press(1'b1, 1'b0, 1'b1, 4'd3, 2'd0, 5);
      chk_val("s6_eq_prio_state", int'(state), 2);
      chk_val("s6_eq_prio_res", int'(disp_val), 5);

      // chaining: 3 + 4 = , + 1 =
      do_reset();
      key_d(4'd3); key_o(2'd1); key_d(4'd4); key_e();
      chk_val("s7_res", int'(disp_val), 7);
      key_o(2'd1);
`ifdef CALC_CHAIN_EN
      chk_val("s7_chain_state", int'(state), 1);
      chk_val("s7_chain_disp", int'(disp_val), 7);
      key_d(4'd1);
      chk_val("s7_b1", int'(disp_val), 1);
      key_e();
      chk_val("s7_final", int'(disp_val), 8);
      chk_val("s7_final_state", int'(state), 2);
`else
      chk_val("s7_ign_state", int'(state), 2);
      chk_val("s7_ign_disp", int'(disp_val), 7);
      key_d(4'd1);
      chk_val("s7_newa_state", int'(state), 0);
      chk_val("s7_newa_disp", int'(disp_val), 1);
      key_e();
      chk_val("s7_final", int'(disp_val), 1);
      chk_val("s7_final_state", int'(state), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
